// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared FSM states, fail codes and word addresses for the system-ID check master.
package sysid_check_pkg;
  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, COMPARE, FINISH} state_e;
  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ID      = 2'd1;
  localparam logic [1:0] FAIL_TS      = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
endpackage

// File: rtl/sysid_check_master_if.sv
// sysid_check_master_if: Avalon-MM read-only bus between the check master and the system-ID slave.
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata
  );
  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdatavalid, avm_readdata
  );
endinterface

// File: rtl/sysid_check_timeout.sv
// sysid_check_timeout: loadable saturating down-counter; expired is high while the count sits at zero.
module sysid_check_timeout #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : clr ? '0 : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    expired = cnt_q == '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= INIT;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sysid_check_master.sv
// sysid_check_master: reads ID and timestamp words from the system-ID slave and reports pass/fail.
// Define SYSID_CHECK_PERIODIC_EN to re-run the check automatically every PERIOD_CYCLES.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1423252379,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 2,
  parameter int          PERIOD_CYCLES      = 1000000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  sysid_check_master_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [31:0]                 id_q,
  output logic [31:0]                 ts_q,
  output logic [1:0]                  fail_code
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || MAX_RETRIES < 0 || MAX_RETRIES > 7 ||
      PERIOD_CYCLES < 1) begin : g_bad_param
    $error("sysid_check_master: parameter out of range");
  end
  state_e      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic        rd_q, rd_d, addr_q, addr_d;
  logic [31:0] id_d, ts_d;
  logic [1:0]  fail_code_q, fail_code_d;
  logic [2:0]  retry_q, retry_d;
  logic        tmr_load, tmr_exp, tmo, go, in_xfer;
  assign in_xfer = state_q inside {ID_REQ, ID_WAIT, TS_REQ, TS_WAIT};
  sysid_check_timeout #(.W(16)) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .clr      (state_q == IDLE),
    .en       (in_xfer),
    .load_val (16'(TIMEOUT_CYCLES - 1)),
    .expired  (tmr_exp)
  );
`ifdef SYSID_CHECK_PERIODIC_EN
  localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
  logic per_exp, auto_start;
  assign auto_start = per_exp && state_q == IDLE;
  sysid_check_timeout #(.W(PER_W), .INIT(PER_W'(PERIOD_CYCLES - 1))) u_period (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (auto_start || state_q == FINISH),
    .clr      (1'b0),
    .en       (1'b1),
    .load_val (PER_W'(PERIOD_CYCLES - 1)),
    .expired  (per_exp)
  );
  assign go = start || auto_start;
`else
  assign go = start;
`endif
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    id_d        = id_q;
    ts_d        = ts_q;
    fail_code_d = fail_code_q;
    retry_d     = retry_q;
    tmr_load    = 1'b0;
    tmo         = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d     = ID_REQ;
        busy_d      = 1'b1;
        retry_d     = '0;
        fail_code_d = FAIL_NONE;
        tmr_load    = 1'b1;
      end
      ID_REQ: if (!avm.avm_waitrequest) begin
        if (avm.avm_readdatavalid) begin
          id_d     = avm.avm_readdata;
          state_d  = TS_REQ;
          tmr_load = 1'b1;
        end else state_d = ID_WAIT;
      end else tmo = tmr_exp;
      ID_WAIT: if (avm.avm_readdatavalid) begin
        id_d     = avm.avm_readdata;
        state_d  = TS_REQ;
        tmr_load = 1'b1;
      end else tmo = tmr_exp;
      TS_REQ: if (!avm.avm_waitrequest) begin
        if (avm.avm_readdatavalid) begin
          ts_d    = avm.avm_readdata;
          state_d = COMPARE;
        end else state_d = TS_WAIT;
      end else tmo = tmr_exp;
      TS_WAIT: if (avm.avm_readdatavalid) begin
        ts_d    = avm.avm_readdata;
        state_d = COMPARE;
      end else tmo = tmr_exp;
      COMPARE: begin
        fail_code_d = id_q != EXPECTED_ID ? FAIL_ID :
                      ts_q != EXPECTED_TIMESTAMP ? FAIL_TS : FAIL_NONE;
        state_d     = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        pass_d  = fail_code_q == FAIL_NONE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A timeout restarts the whole sequence from the ID word while retries remain.
    if (tmo) begin
      if (retry_q < 3'(MAX_RETRIES)) begin
        retry_d  = retry_q + 3'd1;
        state_d  = ID_REQ;
        tmr_load = 1'b1;
      end else begin
        fail_code_d = FAIL_TIMEOUT;
        state_d     = FINISH;
      end
    end
    rd_d   = state_d == ID_REQ || state_d == TS_REQ;
    addr_d = state_d == TS_REQ ? ADDR_TS : ADDR_ID;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= ADDR_ID;
      id_q        <= '0;
      ts_q        <= '0;
      fail_code_q <= FAIL_NONE;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
      fail_code_q <= fail_code_d;
      retry_q     <= retry_d;
    end
  assign avm.avm_read    = rd_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_code       = fail_code_q;
endmodule
